// File: rtl/time_display_pkg.sv
// Shared types and constants for the countdown display: converter FSM states
// and active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package time_display_pkg;

  localparam int unsigned BinW = 7;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles render blank rather than garbage.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/time_display_bin2bcd7.sv
// Sequential double-dabble: 7-bit binary to three BCD digits.
// start_i is accepted only in idle; busy_o covers the shift and done cycles,
// and done_o marks the single cycle in which the digits and value_o are valid.
module bin2bcd7
  import time_display_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [BinW-1:0] bin_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [BinW-1:0] value_o,
  output logic [3:0]      hundreds_o,
  output logic [3:0]      tens_o,
  output logic [3:0]      ones_o
);

  conv_state_e     state_q, state_d;
  // {hundreds, tens, ones, binary}
  logic [18:0]     shreg_q, shreg_d;
  logic [2:0]      iter_q, iter_d;
  logic [BinW-1:0] value_q, value_d;
  logic [11:0]     bcd_adj;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      iter_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      iter_q  <= iter_d;
      value_q <= value_d;
    end
  end

  // Next-state: capture, seven add-3/shift iterations, then one done cycle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    iter_d  = iter_q;
    value_d = value_q;
    bcd_adj = {add3(shreg_q[18:15]), add3(shreg_q[14:11]), add3(shreg_q[10:7])};
    case (state_q)
      StIdle: begin
        if (start_i) begin
          value_d = bin_i;
          shreg_d = {12'd0, bin_i};
          iter_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = {bcd_adj[10:0], shreg_q[6:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd6) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign value_o    = value_q;
  assign hundreds_o = shreg_q[18:15];
  assign tens_o     = shreg_q[14:11];
  assign ones_o     = shreg_q[10:7];

endmodule

// File: rtl/time_display.sv
// Countdown display: converts the countdown value to BCD and drives a
// 4-digit multiplexed active-low 7-segment display. Once expired (live=0)
// the leftmost digit shows a dash and the whole display blinks.
module time_display
  import time_display_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BinW-1:0] time_in,
  input  logic            live,
  output logic [3:0]      an,
  output logic [6:0]      seg,
  output logic            dp,
  output logic            busy
);

  localparam int unsigned ScanDiv   = CLK_HZ / (SCAN_HZ * 4);
  localparam int unsigned BlinkHalf = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned ScanW     = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  localparam int unsigned BlinkW    = (BlinkHalf > 1) ? $clog2(BlinkHalf) : 1;

  logic              conv_busy, conv_done, conv_start;
  logic [BinW-1:0]   conv_value;
  logic [3:0]        conv_hun, conv_ten, conv_one;

  logic [3:0]        hun_q, hun_d, ten_q, ten_d, one_q, one_d;
  logic [BinW-1:0]   last_q, last_d;
  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [6:0]        digit_seg;

  // A new conversion starts only once the previous one has fully committed.
  assign conv_start = !conv_busy && (time_in != last_q);

  bin2bcd7 u_bin2bcd7 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (conv_start),
    .bin_i      (time_in),
    .busy_o     (conv_busy),
    .done_o     (conv_done),
    .value_o    (conv_value),
    .hundreds_o (conv_hun),
    .tens_o     (conv_ten),
    .ones_o     (conv_one)
  );

  // State register: display digits, scan and blink timing, registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hun_q       <= '0;
      ten_q       <= '0;
      one_q       <= '0;
      last_q      <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
    end else begin
      hun_q       <= hun_d;
      ten_q       <= ten_d;
      one_q       <= one_d;
      last_q      <= last_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  // Next-state: digit commit, scan advance, blink phase and digit mux.
  always_comb begin
    hun_d       = hun_q;
    ten_d       = ten_q;
    one_d       = one_q;
    last_d      = last_q;
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    digit_seg   = SEG_BLANK;

    // All three digits land together so a half-updated number never shows.
    if (conv_done) begin
      hun_d  = conv_hun;
      ten_d  = conv_ten;
      one_d  = conv_one;
      last_d = conv_value;
    end

    if (scan_cnt_q == ScanW'(ScanDiv - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    if (live) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BlinkW'(BlinkHalf - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    unique case (idx_q)
      2'd0: digit_seg = seg_decode(one_q);
      2'd1: digit_seg = (hun_q == 4'd0 && ten_q == 4'd0) ? SEG_BLANK : seg_decode(ten_q);
      2'd2: digit_seg = (hun_q == 4'd0) ? SEG_BLANK : seg_decode(hun_q);
      2'd3: digit_seg = live ? SEG_BLANK : SEG_DASH;
      default: digit_seg = SEG_BLANK;
    endcase

    an_d  = ~(4'b0001 << idx_q);
    // live is used directly so a return to running un-blanks on this edge.
    seg_d = (!live && !blink_on_q) ? SEG_BLANK : digit_seg;
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = conv_busy;

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display with a fast clock setup: scan tick every
// 5 clocks, blink half-period 20 clocks. Outputs are sampled on the falling
// edge; inputs change there too, ahead of the next rising edge.
module tb_time_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] time_in;
  logic       live;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int passed = 0;
  int total  = 0;
  // Rising edges since reset release; drives the expected scan position.
  int k = 0;

  always #5 clk = ~clk;

  time_display #(
    .CLK_HZ   (1000),
    .SCAN_HZ  (50),
    .BLINK_HZ (25)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .time_in (time_in),
    .live    (live),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int cyc);
    logic [3:0] one;
    one = 4'b0001;
    if (cyc == 0) return 4'b1111;
    return ~(one << (((cyc - 1) / 5) % 4));
  endfunction

  function automatic logic [6:0] exp_seg(input logic [3:0] a, input int shown, input bit lv,
                                         input bit on);
    if (a == 4'b1111 || !on) return 7'h7F;
    case (a)
      4'b1110: return seg_of(shown % 10);
      4'b1101: return (shown >= 10) ? seg_of((shown / 10) % 10) : 7'h7F;
      4'b1011: return (shown >= 100) ? seg_of(shown / 100) : 7'h7F;
      4'b0111: return lv ? 7'h7F : 7'b0111111;
      default: return 7'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s (k=%0d): observed %b expected %b", tag, k, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  // One clock: check scan position, segments for the shown value and blink
  // phase, and busy (skipped when busy_exp < 0).
  task automatic cyc(input int shown, input bit on, input int busy_exp);
    logic [3:0] ea;
    step();
    ea = exp_an(k);
    check("an", {4'b0, an}, {4'b0, ea});
    check("seg", {1'b0, seg}, {1'b0, exp_seg(ea, shown, live, on)});
    if (busy_exp >= 0) check("busy", {7'b0, busy}, busy_exp[7:0]);
  endtask

  task automatic reset_edge();
    rst = 1'b1;
    step();
    check("rst_an", {4'b0, an}, 8'h0F);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_dp", {7'b0, dp}, 8'h01);
    rst = 1'b0;
    k   = 0;
  endtask

  initial begin
    rst     = 1'b1;
    live    = 1'b1;
    time_in = 7'd100;
    step();
    reset_edge();

    // 1: first conversion of 100, busy for 8 clocks, then 1,0,0.
    repeat (8) cyc(0, 1, 1);
    cyc(0, 1, 0);
    repeat (20) cyc(100, 1, 0);

    // 2: 100 -> 99, old digits through N+8, new from N+9.
    time_in = 7'd99;
    repeat (8) cyc(100, 1, 1);
    cyc(100, 1, 0);
    repeat (20) cyc(99, 1, 0);

    // 3: single digit, then the maximum value.
    time_in = 7'd7;
    repeat (9) cyc(99, 1, -1);
    repeat (20) cyc(7, 1, 0);
    time_in = 7'd127;
    repeat (9) cyc(7, 1, -1);
    repeat (20) cyc(127, 1, 0);

    // 4: change while busy; 50 completes, then 49 is converted.
    time_in = 7'd50;
    repeat (3) cyc(127, 1, 1);
    time_in = 7'd49;
    repeat (5) cyc(127, 1, 1);
    cyc(127, 1, 0);
    repeat (8) cyc(50, 1, 1);
    cyc(50, 1, 0);
    repeat (20) cyc(49, 1, 0);

    // 5: expiry: dash and blink, then live returns during the off phase.
    time_in = 7'd0;
    repeat (9) cyc(49, 1, -1);
    repeat (5) cyc(0, 1, 0);
    live = 1'b0;
    repeat (20) cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    repeat (20) cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 0);
    live = 1'b1;
    repeat (10) cyc(0, 1, 0);

    // 6: reset in the middle of a conversion, then convert 42.
    time_in = 7'd55;
    repeat (3) cyc(0, 1, 1);
    time_in = 7'd42;
    reset_edge();
    repeat (8) cyc(0, 1, 1);
    cyc(0, 1, 0);
    repeat (20) cyc(42, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
